elevator_input_conditioner: RTL and testbench

// - Receives the raw panel inputs of the elevator: three active-low call buttons and the sos/weight toggle switches.
// - Turns them into clean, single-cycle requests and level flags for the elevator controller inside TOP.
// - Sits between the board pins and the controller FSM.
// - Also owns the passenger counter and the weight-limit flag.

---
 rtl/elevator_pkg.sv | 12 +
 rtl/elevator_input_conditioner_debouncer.sv | 67 ++++++
 rtl/elevator_input_conditioner.sv | 122 ++++++++++++
 tb/tb_elevator_input_conditioner.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants for the elevator panel logic: floor indexing and the
// default timing/capacity settings used by the input conditioner.
package elevator_pkg;
  localparam int NUM_FLOORS              = 3;
  localparam int FLOOR1_IDX              = 0;
  localparam int FLOOR2_IDX              = 1;
  localparam int FLOOR3_IDX              = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 8;
  localparam int DEFAULT_MAX_PEOPLE      = 15;
  localparam int DEFAULT_WEIGHT_LIMIT    = 6;
  localparam int DEFAULT_CNT_W           = 4;
endpackage

// File: rtl/elevator_input_conditioner_debouncer.sv
// One raw panel input: 2-FF synchronizer, stability filter and the accepted
// (stable) level, with single-cycle rise/fall flags on each accepted change.
module input_debouncer #(
  parameter logic RESET_VAL       = 1'b0,
  parameter int   DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic prime,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          rise_r;
  logic          fall_r;
  logic [CW-1:0] cnt_r;

  // Two-stage synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= RESET_VAL;
      sync2_r <= RESET_VAL;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Filter: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= RESET_VAL;
      cnt_r    <= '0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else if (prime) begin
      stable_r <= sync2_r;
      cnt_r    <= '0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= '0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else if (cnt_r == LAST) begin
      stable_r <= sync2_r;
      cnt_r    <= '0;
      rise_r   <= sync2_r;
      fall_r   <= ~sync2_r;
    end else begin
      cnt_r    <= cnt_r + CW'(1);
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
    end
  end

  assign stable = stable_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
endmodule

// File: rtl/elevator_input_conditioner.sv
// Conditions the raw elevator panel pins into clean call pulses, the SOS level
// and toggle, and the passenger count with its weight-limit flag.
module elevator_input_conditioner
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int MAX_PEOPLE      = DEFAULT_MAX_PEOPLE,
  parameter int WEIGHT_LIMIT    = DEFAULT_WEIGHT_LIMIT,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic                  clk_50,
  input  logic                  button_reset_pushed,
  input  logic                  button1_pushed,
  input  logic                  button2_pushed,
  input  logic                  button3_pushed,
  input  logic                  sos_flip,
  input  logic                  weight_flip,
  input  logic                  weight_flip_reset,
  output logic [NUM_FLOORS-1:0] call_req,
  output logic                  sos_mode,
  output logic                  sos_toggle,
  output logic [CNT_W-1:0]      people_count,
  output logic                  weight_limit_exceeded
);
  localparam int            STARTUP = DEBOUNCE_CYCLES + 2;
  localparam int            SW      = $clog2(STARTUP + 1);
  localparam logic [SW-1:0] SU_END  = SW'(STARTUP);

  logic                  rst_n_s;
  logic                  prime_s;
  logic [SW-1:0]         startup_cnt_r;
  logic [NUM_FLOORS-1:0] btn_raw_s;
  logic [NUM_FLOORS-1:0] btn_stable_s;
  logic [NUM_FLOORS-1:0] btn_rise_s;
  logic [NUM_FLOORS-1:0] btn_fall_s;
  logic                  sos_stable_s, sos_rise_s, sos_fall_s;
  logic                  wf_stable_s, wf_rise_s, wf_fall_s;
  logic                  wfr_stable_s, wfr_rise_s, wfr_fall_s;
  logic [NUM_FLOORS-1:0] call_req_r;
  logic                  sos_toggle_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_next_s;
  logic                  limit_r;
  logic                  unused_s;

  assign rst_n_s               = button_reset_pushed;
  assign prime_s               = (startup_cnt_r != SU_END);
  assign btn_raw_s[FLOOR1_IDX] = button1_pushed;
  assign btn_raw_s[FLOOR2_IDX] = button2_pushed;
  assign btn_raw_s[FLOOR3_IDX] = button3_pushed;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    input_debouncer #(.RESET_VAL(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk(clk_50), .rst_n(rst_n_s), .raw(btn_raw_s[i]), .prime(prime_s),
      .stable(btn_stable_s[i]), .rise(btn_rise_s[i]), .fall(btn_fall_s[i])
    );
  end

  input_debouncer #(.RESET_VAL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sos (
    .clk(clk_50), .rst_n(rst_n_s), .raw(sos_flip), .prime(prime_s),
    .stable(sos_stable_s), .rise(sos_rise_s), .fall(sos_fall_s)
  );
  input_debouncer #(.RESET_VAL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wf (
    .clk(clk_50), .rst_n(rst_n_s), .raw(weight_flip), .prime(prime_s),
    .stable(wf_stable_s), .rise(wf_rise_s), .fall(wf_fall_s)
  );
  input_debouncer #(.RESET_VAL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wfr (
    .clk(clk_50), .rst_n(rst_n_s), .raw(weight_flip_reset), .prime(prime_s),
    .stable(wfr_stable_s), .rise(wfr_rise_s), .fall(wfr_fall_s)
  );

  // Only the press edge of a button and the switch levels/toggles are consumed.
  assign unused_s = &{1'b0, btn_rise_s, btn_stable_s, wf_stable_s, wfr_stable_s};

  // Startup window: debouncers adopt the pin levels silently until this saturates.
  always_ff @(posedge clk_50 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      startup_cnt_r <= '0;
    end else if (prime_s) begin
      startup_cnt_r <= startup_cnt_r + SW'(1);
    end else begin
      startup_cnt_r <= startup_cnt_r;
    end
  end

  // Passenger count next value: clear beats increment; increment saturates.
  always_comb begin
    count_next_s = count_r;
    if (wfr_rise_s || wfr_fall_s) begin
      count_next_s = '0;
    end else if (wf_rise_s || wf_fall_s) begin
      if (count_r == CNT_W'(MAX_PEOPLE)) begin
        count_next_s = count_r;
      end else begin
        count_next_s = count_r + CNT_W'(1);
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Registered event pulses, count and limit flag.
  always_ff @(posedge clk_50 or negedge rst_n_s) begin
    if (!rst_n_s) begin
      call_req_r   <= '0;
      sos_toggle_r <= 1'b0;
      count_r      <= '0;
      limit_r      <= 1'b0;
    end else begin
      call_req_r   <= btn_fall_s;
      sos_toggle_r <= sos_rise_s | sos_fall_s;
      count_r      <= count_next_s;
      limit_r      <= (count_next_s > CNT_W'(WEIGHT_LIMIT));
    end
  end

  assign call_req              = call_req_r;
  assign sos_mode              = sos_stable_s;
  assign sos_toggle            = sos_toggle_r;
  assign people_count          = count_r;
  assign weight_limit_exceeded = limit_r;
endmodule

// File: tb/tb_elevator_input_conditioner.sv
// Directed bench: event pulses are checked against a cycle-stamped scoreboard,
// levels and counts are checked inline by the stimulus sequence.
module tb_elevator_input_conditioner;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n, b1, b2, b3, sos, wf, wfr;
  logic [2:0] call_req;
  logic       sos_mode, sos_toggle, limit;
  logic [3:0] count;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int       cyc;
    logic [2:0] cr;
    logic     st;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elevator_input_conditioner dut (
    .clk_50(clk), .button_reset_pushed(rst_n),
    .button1_pushed(b1), .button2_pushed(b2), .button3_pushed(b3),
    .sos_flip(sos), .weight_flip(wf), .weight_flip_reset(wfr),
    .call_req(call_req), .sos_mode(sos_mode), .sos_toggle(sos_toggle),
    .people_count(count), .weight_limit_exceeded(limit)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_ev(input int at, input logic [2:0] cr, input logic st);
    ev_t e;
    e.cyc = at;
    e.cr  = cr;
    e.st  = st;
    exp_q.push_back(e);
  endtask

  // Event monitor: expected pulses must appear on their cycle, nothing else may pulse.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ev_t e;
      e = exp_q.pop_front();
      vectors++;
      assert ({call_req, sos_toggle} === {e.cr, e.st}) else begin
        miscompares++;
        $error("FAIL event@%0d: observed call_req=%b sos_toggle=%b expected call_req=%b sos_toggle=%b",
               cyc, call_req, sos_toggle, e.cr, e.st);
      end
    end else if (call_req !== 3'b000 || sos_toggle !== 1'b0) begin
      vectors++;
      assert ({call_req, sos_toggle} === 4'b0000) else begin
        miscompares++;
        $error("FAIL spurious@%0d: observed call_req=%b sos_toggle=%b expected none",
               cyc, call_req, sos_toggle);
      end
    end
  end

  initial begin
    rst_n = 1'b0; b1 = 1'b1; b2 = 1'b1; b3 = 1'b1;
    sos = 1'b0; wf = 1'b0; wfr = 1'b0;
    tick(3);
    check("rst_call_req", call_req, 0);
    check("rst_sos_toggle", sos_toggle, 0);
    check("rst_sos_mode", sos_mode, 0);
    check("rst_count", count, 0);
    check("rst_limit", limit, 0);
    rst_n = 1'b1;
    tick(D + 4);

    // T1: press floor 3, pulse 11 cycles later, none on release
    b3 = 1'b0; push_ev(cyc + D + 3, 3'b100, 1'b0);
    tick(12); b3 = 1'b1; tick(15);

    // T2: short glitch is rejected; bounce train gives one pulse
    b1 = 1'b0; tick(3); b1 = 1'b1; tick(15);
    b1 = 1'b0; tick(2); b1 = 1'b1; tick(1);
    b1 = 1'b0; push_ev(cyc + D + 3, 3'b001, 1'b0);
    tick(20); b1 = 1'b1; tick(15);

    // Simultaneous presses pulse together
    b1 = 1'b0; b2 = 1'b0; push_ev(cyc + D + 3, 3'b011, 1'b0);
    tick(12); b1 = 1'b1; b2 = 1'b1; tick(15);

    // SOS level and toggle on both edges
    sos = 1'b1; push_ev(cyc + D + 3, 3'b000, 1'b1);
    tick(12); check("sos_mode_on", sos_mode, 1);
    sos = 1'b0; push_ev(cyc + D + 3, 3'b000, 1'b1);
    tick(12); check("sos_mode_off", sos_mode, 0);

    // T3: seven toggles, checked one cycle before and on the update cycle
    for (int i = 1; i <= 7; i++) begin
      wf = ~wf;
      tick(D + 2);
      check("count_before", count, i - 1);
      check("limit_before", limit, (i - 1) > 6);
      tick(1);
      check("count_after", count, i);
      check("limit_after", limit, i > 6);
      tick(1);
    end

    // T4: clear, then clear and increment in the same cycle
    wfr = ~wfr; tick(12);
    check("clear_count", count, 0);
    check("clear_limit", limit, 0);
    wf = ~wf; tick(12); wf = ~wf; tick(12);
    check("count_two", count, 2);
    wf = ~wf; wfr = ~wfr; tick(12);
    check("priority_count", count, 0);

    // T5: saturation, then reset with SOS already on
    repeat (20) begin
      wf = ~wf; tick(12);
    end
    check("sat_count", count, 15);
    check("sat_limit", limit, 1);
    rst_n = 1'b0; sos = 1'b1; tick(2);
    check("rst2_count", count, 0);
    rst_n = 1'b1; tick(D + 4);
    check("startup_sos_mode", sos_mode, 1);
    check("startup_count", count, 0);
    tick(10);

    // T6: reset four cycles into a floor-2 press
    wf = ~wf; tick(12); wf = ~wf; tick(12);
    check("pre_t6_count", count, 2);
    b2 = 1'b0; tick(4);
    rst_n = 1'b0; #1;
    check("t6_call_req", call_req, 0);
    check("t6_sos_toggle", sos_toggle, 0);
    check("t6_sos_mode", sos_mode, 0);
    check("t6_count", count, 0);
    check("t6_limit", limit, 0);
    tick(3); rst_n = 1'b1; tick(30);
    b2 = 1'b1; tick(15);

    check("events_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
